mux_rr_scheduler: RTL and testbench

MUX_RR_SCHEDULER -- requirements
Module: mux_rr_scheduler

---
 rtl/mux_sched_pkg.sv | 13 +
 rtl/rr_pick.sv | 30 +++
 rtl/mux_rr_scheduler.sv | 106 ++++++++++
 tb/tb_mux_rr_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared state encoding and default sizing for the round-robin mux scheduler.
package mux_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_SEL_WIDTH  = 4;
   localparam int DEF_BURST_LEN  = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit after ptr, wrapping.
module rr_pick #(
   parameter int DATA_WIDTH = 16,
   parameter int SEL_WIDTH  = 4
) (
   input  logic [DATA_WIDTH-1:0] req,
   input  logic [SEL_WIDTH-1:0]  ptr,
   input  logic                  exclude,
   output logic [SEL_WIDTH-1:0]  winner,
   output logic                  found
);

   logic [SEL_WIDTH-1:0] idx;

   // Scan from the farthest offset down so the nearest hit wins; offset
   // DATA_WIDTH lands back on ptr itself, which exclude can mask out.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = DATA_WIDTH; i >= 1; i--) begin
         idx = ptr + SEL_WIDTH'(i);
         if (req[idx] && !(exclude && (i == DATA_WIDTH))) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler granting one serial input at a time for bursts of
// up to BURST_LEN accepted beats, with back-to-back grant handover.
module mux_rr_scheduler
   import mux_sched_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
   parameter int BURST_LEN  = DEF_BURST_LEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] req,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  out_ready,
   output logic [SEL_WIDTH-1:0]  sel,
   output logic [DATA_WIDTH-1:0] grant,
   output logic                  out,
   output logic                  out_valid,
   output logic                  busy
);

   localparam logic [7:0]            LAST_BEAT = 8'(BURST_LEN - 1);
   localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);

   state_t                state, state_nx;
   logic [SEL_WIDTH-1:0]  sel_nx, ptr, ptr_nx, pick_ptr, winner;
   logic [7:0]            beat_cnt, cnt_nx;
   logic [DATA_WIDTH-1:0] grant_nx;
   logic                  found, exclude, accepted, burst_end;

   assign out       = in[sel];
   assign busy      = (state == GRANT);
   assign out_valid = busy && req[sel];
   assign accepted  = out_valid && out_ready;
   assign burst_end = busy && ((accepted && (beat_cnt == LAST_BEAT)) || !req[sel]);

   // While granted, the next search starts after the current owner, which is
   // passed over unless nobody else is asking.
   assign pick_ptr = busy ? sel : ptr;
   assign exclude  = busy && |(req & ~(ONE << sel));

   rr_pick #(
      .DATA_WIDTH(DATA_WIDTH),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .exclude(exclude),
      .winner (winner),
      .found  (found)
   );

   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      ptr_nx   = ptr;
      cnt_nx   = beat_cnt;
      grant_nx = grant;
      case (state)
         IDLE: begin
            if (found) begin
               state_nx = GRANT;
               sel_nx   = winner;
               cnt_nx   = '0;
               grant_nx = ONE << winner;
            end
         end
         GRANT: begin
            if (burst_end) begin
               ptr_nx = sel;
               cnt_nx = '0;
               if (found) begin
                  sel_nx   = winner;
                  grant_nx = ONE << winner;
               end else begin
                  state_nx = IDLE;
                  grant_nx = '0;
               end
            end else if (accepted) begin
               cnt_nx = beat_cnt + 8'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            grant_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= '0;
         grant    <= '0;
         beat_cnt <= '0;
         ptr      <= SEL_WIDTH'(DATA_WIDTH - 1);
      end else begin
         state    <= state_nx;
         sel      <= sel_nx;
         grant    <= grant_nx;
         beat_cnt <= cnt_nx;
         ptr      <= ptr_nx;
      end
   end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench: directed bursts push expected beats, a monitor pops them.
module tb_mux_rr_scheduler;

   localparam int DW = 16;
   localparam int SW = 4;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] req = '0;
   logic [DW-1:0] in = '0;
   logic [SW-1:0] sel;
   logic [DW-1:0] grant;
   logic          out, out_valid, busy;

   mux_rr_scheduler #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .BURST_LEN(BL)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .in(in), .out_ready(out_ready),
      .sel(sel), .grant(grant), .out(out), .out_valid(out_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [SW-1:0] sel;
      logic          out;
   } beat_t;

   beat_t         exp_q[$];
   beat_t         b;
   int            total = 0;
   int            passed = 0;
   bit            chk_q = 1'b1;
   logic [DW-1:0] prev_grant = '0;
   int            wait_cnt[DW];
   int            max_wait = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input logic o, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back('{sel: SW'(s), out: o});
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; in = '0; out_ready = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   // Invariants every cycle plus in-order comparison of accepted beats.
   always @(negedge clk) begin
      if (rst_n) begin
         check("onehot0", 32'($onehot0(grant)), 32'd1);
         check("grant_vs_sel", 32'(grant), busy ? (32'd1 << sel) : 32'd0);
         check("out_mux", 32'(out), 32'(in[sel]));
         check("out_valid", 32'(out_valid), 32'(busy && req[sel]));
         if (out_valid && out_ready && chk_q) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_beat: got sel=%0d out=%0b expected no beat at %0t", sel, out, $time);
            end else begin
               b = exp_q.pop_front();
               check("beat_sel", 32'(sel), 32'(b.sel));
               check("beat_out", 32'(out), 32'(b.out));
            end
         end
      end
   end

   // Counts how many grant handovers each waiting requester sits through.
   always @(negedge clk) begin
      if (rst_n && !chk_q && grant != prev_grant && grant != '0) begin
         for (int i = 0; i < DW; i++) begin
            if (req[i] && !grant[i]) begin
               wait_cnt[i]++;
               if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end else begin
               wait_cnt[i] = 0;
            end
         end
      end
      prev_grant = grant;
   end

   logic [DW-1:0] g2[4];

   initial begin
      for (int i = 0; i < DW; i++) wait_cnt[i] = 0;
      g2[0] = 16'h0001; g2[1] = 16'h0100; g2[2] = 16'h8000; g2[3] = 16'h0001;

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);

      // Sole requester 0: two back-to-back bursts, no gap
      step(1);
      req = 16'h0001; in = 16'h0001; out_ready = 1'b1;
      push(0, 1'b1, 8);
      @(negedge clk);
      check("t1_latency", 32'(grant), 32'd0);
      step(1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("t1_grant", 32'(grant), 32'h0001);
         check("t1_busy", 32'(busy), 32'd1);
         step(1);
      end
      req = '0;
      @(negedge clk);
      step(1);
      @(negedge clk);
      check("t1_idle", 32'(busy), 32'd0);
      check("t1_drain", exp_q.size(), 32'd0);

      // Three requesters: order 0,8,15,0 with 4 beats each
      do_reset();
      req = 16'h8101; in = 16'h8001; out_ready = 1'b1;
      push(0, 1'b1, 4); push(8, 1'b0, 4); push(15, 1'b1, 4); push(0, 1'b1, 4);
      @(negedge clk);
      check("t2_latency", 32'(grant), 32'd0);
      step(1);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check("t2_grant", 32'(grant), 32'(g2[k/4]));
         step(1);
      end
      req = '0;
      @(negedge clk);
      check("t2_next", 32'(grant), 32'h0100);
      step(1);
      @(negedge clk);
      check("t2_idle", 32'(busy), 32'd0);
      check("t2_drain", exp_q.size(), 32'd0);

      // Index 3 under toggling out_ready: 4 beats before handing to index 4
      do_reset();
      req = 16'h0018; in = 16'h0008;
      push(3, 1'b1, 4);
      step(1);
      for (int k = 1; k <= 8; k++) begin
         out_ready = k[0];
         @(negedge clk);
         check("t3_grant", 32'(grant), (k <= 7) ? 32'h0008 : 32'h0010);
         step(1);
      end
      req = '0; out_ready = 1'b0;
      @(negedge clk);
      step(1);
      @(negedge clk);
      check("t3_idle", 32'(busy), 32'd0);
      check("t3_drain", exp_q.size(), 32'd0);

      // req[5] drops after 2 beats: 9 takes over, full 4-beat burst, then 0
      do_reset();
      req = 16'h0220; in = 16'h0200; out_ready = 1'b1;
      push(5, 1'b0, 2); push(9, 1'b1, 4);
      step(1);
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         check("t4_grant5", 32'(grant), 32'h0020);
         step(1);
      end
      req = 16'h0201;
      @(negedge clk);
      check("t4_hold5", 32'(grant), 32'h0020);
      check("t4_novalid", 32'(out_valid), 32'd0);
      step(1);
      for (int k = 4; k <= 7; k++) begin
         @(negedge clk);
         check("t4_grant9", 32'(grant), 32'h0200);
         step(1);
      end
      req = '0;
      @(negedge clk);
      check("t4_next", 32'(grant), 32'h0001);
      step(1);
      @(negedge clk);
      check("t4_idle", 32'(busy), 32'd0);
      check("t4_drain", exp_q.size(), 32'd0);

      // Reset mid-burst with everyone requesting
      do_reset();
      req = 16'hFFFF; in = 16'hAAAA; out_ready = 1'b1;
      push(0, 1'b0, 2);
      step(3);
      rst_n = 1'b0;
      @(negedge clk);
      step(1);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_grant", 32'(grant), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_valid", 32'(out_valid), 32'd0);
      step(1);
      req = '0;
      @(negedge clk);
      check("t5_first", 32'(grant), 32'h0001);
      check("t5_sel", 32'(sel), 32'd0);
      step(2);
      check("t5_drain", exp_q.size(), 32'd0);

      // Random traffic: invariants and starvation bound
      do_reset();
      chk_q = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (c % 5 == 0) req = DW'($urandom) & DW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in = DW'($urandom);
         step(1);
      end
      check("starvation", 32'(max_wait <= 15), 32'd1);
      do_reset();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
